// File: rtl/hazard_ctrl.sv
// Purpose  : pipeline hazard controller (load-use stall, branch flush window, memory freeze) with perf counters.
// Latency  : control outputs are combinational from state + inputs; state and counters update on the next clk edge.
// Backpress: mem_busy freezes every stage enable; a held hazard is re-evaluated on the first non-busy cycle.
//
// Ports:
//   clk, rst                  clock / asynchronous active-low reset
//   id_rs1/2, id_use_rs1/2    source registers of the instruction in ID and whether they are read
//   ex_rd, ex_memread         destination of the instruction in EX and whether it is a load
//   ex_br_taken               taken branch/jump resolved in EX (single-cycle pulse)
//   mem_busy                  data memory not ready
//   cnt_clr                   synchronous clear of both performance counters
//   pc_en, ifid_en, idex_en, exmem_en   stage load enables
//   ifid_flush, idex_bubble   squash IF/ID to NOP / load a zero-control bubble into ID/EX
//   state_o                   FSM state (debug)
//   stall_cnt, flush_cnt      saturating count of stalled cycles / accepted taken branches
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_br_taken,
   input  logic             mem_busy,
   input  logic             cnt_clr,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Remaining-flush counter only needs to hold FLUSH_CYCLES-1.
   localparam int RW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   localparam logic [RW-1:0] REM_LOAD = RW'(FLUSH_CYCLES - 1);
   localparam logic [RW-1:0] REM_ONE  = RW'(1);
   localparam state_t        BR_NEXT  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_t          state_q, state_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic            lu_haz;
   logic            lu_live;
   logic            br_acc;

   // Load in EX writing a register that ID reads; x0 is never a hazard.
   assign lu_haz = ex_memread && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));

   // In LU_STALL the bubble already sits in EX, so the old hazard must not re-stall.
   assign lu_live = lu_haz && (state_q != LU_STALL);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // ---------------- next-state logic ----------------
   // RUN, LU_STALL and MEM_WAIT share one rule set; only FLUSH differs.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         FLUSH: begin
            if (!mem_busy) begin
               if (ex_br_taken) begin
                  rem_d = REM_LOAD;
               end else begin
                  rem_d = rem_q - REM_ONE;
                  if (rem_q <= REM_ONE) state_d = RUN;
               end
            end
         end
         default: begin
            if (mem_busy) begin
               state_d = MEM_WAIT;
            end else if (ex_br_taken) begin
               state_d = BR_NEXT;
               rem_d   = REM_LOAD;
            end else if (lu_live) begin
               state_d = LU_STALL;
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      br_acc      = 1'b0;
      if (!rst) begin
         // Safe pipe while reset is held: nothing loads, IF/ID and ID/EX read as NOPs.
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_en     = 1'b0;
         idex_bubble = 1'b1;
         exmem_en    = 1'b0;
      end else if (mem_busy) begin
         // Freeze holds every stage; flush/bubble stay low so frozen registers keep contents.
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (state_q == FLUSH || ex_br_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         br_acc      = ex_br_taken;
      end else if (lu_live) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   assign state_o = state_q;

   // ---------------- performance counters ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (br_acc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose  : self-checking bench for hazard_ctrl; two instances (FLUSH_CYCLES=2/CNT_W=16 and FLUSH_CYCLES=1/CNT_W=4).
// Latency  : inputs change 1 time unit after each rising edge; outputs are checked on the falling edge.
// Backpress: mem_busy is driven both in directed freeze sequences and randomly.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, mem_busy, cnt_clr;

   logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en;
   logic [1:0]  a_state;
   logic [15:0] a_stall, a_flush;
   logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en;
   logic [1:0]  b_state;
   logic [3:0]  b_stall, b_flush;

   logic [5:0] a_ctl, b_ctl;
   assign a_ctl = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en};
   assign b_ctl = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en};

   hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
      .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
      .idex_en(a_idex_en), .idex_bubble(a_idex_bubble), .exmem_en(a_exmem_en),
      .state_o(a_state), .stall_cnt(a_stall), .flush_cnt(a_flush)
   );

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
      .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
      .idex_en(b_idex_en), .idex_bubble(b_idex_bubble), .exmem_en(b_exmem_en),
      .state_o(b_state), .stall_cnt(b_stall), .flush_cnt(b_flush)
   );

   // Control vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en
   localparam logic [5:0] C_RST = 6'b001010;
   localparam logic [5:0] C_FRZ = 6'b000000;
   localparam logic [5:0] C_FLS = 6'b111111;
   localparam logic [5:0] C_LUS = 6'b000111;
   localparam logic [5:0] C_RUN = 6'b110101;

   int checks = 0;
   int errors = 0;
   int probe  = 0;

   // Reference model, per instance: flush cycles still owed, whether the previous
   // cycle was a load-use stall, whether the pipe is waiting on memory, counters.
   int fl   [2];
   bit lup  [2];
   bit wt   [2];
   int sc   [2];
   int fcnt [2];

   function automatic int fc_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   function automatic bit lu_now();
      return ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   endfunction

   task automatic lit(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : chk
      logic [5:0] act_ctl, e_ctl;
      int act_st, act_sc, act_fc, e_st, e_sc, e_fc, n_fl;
      bit n_lup, n_wt, inc_f;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            act_ctl = a_ctl; act_st = int'(a_state); act_sc = int'(a_stall); act_fc = int'(a_flush);
         end else begin
            act_ctl = b_ctl; act_st = int'(b_state); act_sc = int'(b_stall); act_fc = int'(b_flush);
         end
         e_st = 0; n_fl = 0; n_lup = 1'b0; n_wt = 1'b0; inc_f = 1'b0;
         if (!rst) begin
            e_ctl = C_RST; e_sc = 0; e_fc = 0;
            fl[k] = 0; lup[k] = 1'b0; wt[k] = 1'b0; sc[k] = 0; fcnt[k] = 0;
         end else begin
            e_sc = sc[k]; e_fc = fcnt[k]; n_fl = fl[k];
            if (fl[k] > 0) begin
               e_st = 2;
               if (mem_busy)         e_ctl = C_FRZ;
               else if (ex_br_taken) begin e_ctl = C_FLS; n_fl = fc_of(k) - 1; inc_f = 1'b1; end
               else                  begin e_ctl = C_FLS; n_fl = fl[k] - 1; end
            end else begin
               e_st = wt[k] ? 3 : (lup[k] ? 1 : 0);
               if (mem_busy)                      begin e_ctl = C_FRZ; n_wt = 1'b1; end
               else if (ex_br_taken)              begin e_ctl = C_FLS; n_fl = fc_of(k) - 1; inc_f = 1'b1; end
               else if (lu_now() && !lup[k])      begin e_ctl = C_LUS; n_lup = 1'b1; end
               else                               e_ctl = C_RUN;
            end
         end
         checks++;
         if (act_ctl !== e_ctl || act_st != e_st || act_sc != e_sc || act_fc != e_fc) begin
            errors++;
            $display("FAIL model_inst%0d ctl=%b want %b state=%0d want %0d stall=%0d want %0d flush=%0d want %0d at %0t",
                     k, act_ctl, e_ctl, act_st, e_st, act_sc, e_sc, act_fc, e_fc, $time);
         end
         if (rst) begin
            fl[k] = n_fl; lup[k] = n_lup; wt[k] = n_wt;
            if (cnt_clr) begin
               sc[k] = 0; fcnt[k] = 0;
            end else begin
               if (!e_ctl[5] && sc[k] < max_of(k)) sc[k]++;
               if (inc_f && fcnt[k] < max_of(k))   fcnt[k]++;
            end
         end
      end
      // Hand-computed expectations for the directed scenarios.
      case (probe)
         1: begin
            lit("rst_ctl", int'(a_ctl), int'(C_RST));
            lit("rst_state", int'(a_state), 0);
            lit("rst_stall", int'(a_stall), 0);
         end
         2: begin
            lit("lu_pc_en", int'(a_pc_en), 0);
            lit("lu_ifid_en", int'(a_ifid_en), 0);
            lit("lu_bubble", int'(a_idex_bubble), 1);
         end
         3: begin
            lit("lu_next_ctl", int'(a_ctl), int'(C_RUN));
            lit("lu_stall_cnt", int'(a_stall), 1);
            lit("lu_state", int'(a_state), 1);
         end
         4: begin
            lit("nohaz_pc_en", int'(a_pc_en), 1);
            lit("nohaz_state", int'(a_state), 0);
         end
         5: begin
            lit("br0_ctl_a", int'(a_ctl), int'(C_FLS));
            lit("br0_ctl_b", int'(b_ctl), int'(C_FLS));
         end
         6: begin
            lit("br1_flush_a", int'(a_ifid_flush), 1);
            lit("br1_pc_en_a", int'(a_pc_en), 1);
            lit("br1_state_a", int'(a_state), 2);
            lit("br1_flush_cnt_a", int'(a_flush), 1);
            lit("br1_flush_b", int'(b_ifid_flush), 0);
            lit("br1_flush_cnt_b", int'(b_flush), 1);
         end
         7: begin
            lit("br2_state_a", int'(a_state), 0);
            lit("br2_flush_a", int'(a_ifid_flush), 0);
         end
         8: lit("frz_ctl", int'(a_ctl), int'(C_FRZ));
         9: begin
            lit("frz_lu_ctl", int'(a_ctl), int'(C_LUS));
            lit("frz_lu_stall", int'(a_stall), 3);
         end
         10: begin
            lit("frz_end_stall_a", int'(a_stall), 4);
            lit("frz_end_stall_b", int'(b_stall), 4);
            lit("frz_end_pc_en", int'(a_pc_en), 1);
         end
         11: begin
            lit("rstmid_ctl", int'(a_ctl), int'(C_RST));
            lit("rstmid_state", int'(a_state), 0);
            lit("rstmid_flush_cnt", int'(a_flush), 0);
         end
         12: begin
            lit("sat_stall_b", int'(b_stall), 15);
            lit("sat_stall_a", int'(a_stall), 20);
         end
         13: begin
            lit("clr_stall_b", int'(b_stall), 0);
            lit("clr_stall_a", int'(a_stall), 0);
         end
         default: ;
      endcase
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      probe = 0;
   endtask

   task automatic clear_in();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_memread = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic set_lu();
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      clear_in();
      probe = 1;
      cyc(); probe = 1;
      cyc(); rst = 1'b1;
      // load-use stall, then the held hazard is ignored in LU_STALL
      cyc(); set_lu(); probe = 2;
      cyc(); probe = 3;
      // x0 destination and unused source never stall
      cyc(); clear_in(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; probe = 4;
      cyc(); ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd3; probe = 4;
      // taken branch
      cyc(); clear_in(); ex_br_taken = 1'b1; probe = 5;
      cyc(); ex_br_taken = 1'b0; probe = 6;
      cyc(); probe = 7;
      // memory freeze concurrent with a load-use hazard
      cyc(); cnt_clr = 1'b1;
      cyc(); cnt_clr = 1'b0; set_lu(); mem_busy = 1'b1; probe = 8;
      cyc(); probe = 8;
      cyc(); probe = 8;
      cyc(); mem_busy = 1'b0; probe = 9;
      cyc(); clear_in(); probe = 10;
      // reset in the middle of a flush window
      cyc(); ex_br_taken = 1'b1;
      cyc(); ex_br_taken = 1'b0; rst = 1'b0; probe = 11;
      cyc(); rst = 1'b1;
      // counter saturation and clear while stalled
      for (int i = 0; i < 20; i++) begin
         cyc(); mem_busy = 1'b1;
      end
      cyc(); cnt_clr = 1'b1; probe = 12;
      cyc(); cnt_clr = 1'b0; probe = 13;
      cyc(); clear_in();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         rst         = ($urandom_range(0, 199) != 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         ex_memread  = ($urandom_range(0, 1) == 1);
         ex_br_taken = ($urandom_range(0, 9) == 0);
         mem_busy    = ($urandom_range(0, 6) == 0);
         cnt_clr     = ($urandom_range(0, 49) == 0);
      end
      cyc(); rst = 1'b1; clear_in();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
